// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the core and the data memory load/store unit.
interface data_mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_busy;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  // Memory side.
  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );
endinterface

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with integrated load/store unit.
// One request per cycle, registered response one cycle later, optional
// zero-clear of the whole array after reset.
module data_mem_lsu #(
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  data_mem_lsu_if.slave bus
);

  localparam int unsigned NumWords = 1 << DEPTH_LOG2;

  typedef enum logic [0:0] {StClear, StRun} state_e;
  localparam state_e StReset = CLEAR_ON_RESET ? StClear : StRun;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;

  logic [31:0]           mem_q [NumWords];
  logic [31:0]           rd_word_q;

  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  ld_q, ld_d;
  logic [1:0]            size_q, size_d;
  logic [1:0]            off_q, off_d;
  logic                  uns_q, uns_d;

  logic [DEPTH_LOG2-1:0] req_idx;
  logic [1:0]            req_off;
  logic                  out_of_range, misaligned, bad_size, req_err;
  logic                  accept, load_acc;

  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_be;

  logic [31:0]           shifted;
  logic [31:0]           ld_ext;

  assign req_idx = bus.req_addr[DEPTH_LOG2+1:2];
  assign req_off = bus.req_addr[1:0];

  // Request decode and error classification.
  always_comb begin
    out_of_range = (bus.req_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    misaligned   = ((bus.req_size == SzHalf) && req_off[0]) ||
                   ((bus.req_size == SzWord) && (req_off != 2'b00));
    bad_size     = (bus.req_size == 2'b11);
    req_err      = out_of_range || misaligned || bad_size;
    accept       = bus.req_valid && (state_q == StRun);
    load_acc     = accept && !bus.req_we && !req_err;
  end

  // Clear FSM: walk every word once, then open the request port.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d   = StRun;
          clr_cnt_d = '0;
        end
      end
      StRun: ;
      default: state_d = StReset;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StReset;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Write port: clear writes take priority; stores use byte-lane enables with
  // data replicated so every candidate lane already carries the right bits.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = req_idx;
    mem_wdata = 32'd0;
    mem_be    = 4'b0000;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_idx   = clr_cnt_q;
      mem_be    = 4'b1111;
    end else if (accept && bus.req_we && !req_err) begin
      mem_we = 1'b1;
      case (bus.req_size)
        SzByte: begin
          mem_be    = 4'b0001 << req_off;
          mem_wdata = {4{bus.req_wdata[7:0]}};
        end
        SzHalf: begin
          mem_be    = 4'b0011 << req_off;
          mem_wdata = {2{bus.req_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = bus.req_wdata;
        end
      endcase
    end
  end

  // Storage array and synchronous read; the array is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && mem_be[i]) begin
        mem_q[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
    if (load_acc) begin
      rd_word_q <= mem_q[req_idx];
    end
  end

  // Response next-state: size/offset/sign travel with the read word.
  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept && req_err;
    ld_d        = load_acc;
    size_d      = bus.req_size;
    off_d       = req_off;
    uns_d       = bus.req_unsigned;
  end

  // Response registers; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      ld_q        <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      ld_q        <= ld_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
    end
  end

  // Load alignment and extension.
  always_comb begin
    shifted = rd_word_q >> {off_q, 3'b000};
    case (size_q)
      SzByte:  ld_ext = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SzHalf:  ld_ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ld_ext = rd_word_q;
    endcase
  end

  // ld_q is only set for a valid, error-free load, so stores, errors and idle
  // cycles all return zero data.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = ld_q ? ld_ext : 32'd0;
  assign bus.req_ready = (state_q == StRun);
  assign bus.init_busy = (state_q == StClear);

endmodule

// File: tb/tb_data_mem_lsu.sv
// Self-checking bench for data_mem_lsu (16-word array, clear on reset).
module tb_data_mem_lsu;

  localparam int unsigned DepthLog2 = 4;
  localparam int unsigned MemBytes  = 4 << DepthLog2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [7:0] ref_mem [MemBytes];
  vec_t       tbl [23];

  data_mem_lsu_if bus ();

  data_mem_lsu #(
    .DEPTH_LOG2    (DepthLog2),
    .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic vec_t mkv(input logic we, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata,
                               input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  // Reference model: plain byte array, little-endian, arithmetic extension.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic err);
    int unsigned nbytes;
    longint      val;
    nbytes = 1 << size;
    err = (addr >= MemBytes) || (size == 2'd3) || (addr % nbytes != 0);
    rd  = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < int'(nbytes); i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        val = 0;
        for (int i = 0; i < int'(nbytes); i++) val += longint'(ref_mem[addr + i]) << (8 * i);
        if (!uns && nbytes < 4 && val >= (longint'(1) << (8 * nbytes - 1)))
          val -= longint'(1) << (8 * nbytes);
        rd = val[31:0];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(MemBytes); i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
  endtask

  // Called at a negedge: one request, response checked at the next negedge.
  task automatic single(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] mrd;
    logic        merr;
    model_access(we, addr, size, uns, wdata, mrd, merr);
    drive(we, addr, size, uns, wdata);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({name, " valid"}, {31'd0, bus.rsp_valid}, 32'd1);
    check({name, " rdata"}, bus.rsp_rdata, exp_rd);
    check({name, " err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
  endtask

  // From the rst_n release: count cycles until req_ready, optionally holding a
  // store request that must not be accepted.
  task automatic wait_clear(input string name, input logic hold_req);
    int   cnt;
    logic saw_rsp;
    cnt = 0;
    saw_rsp = 1'b0;
    if (hold_req) drive(1'b1, 32'h8, 2'd2, 1'b0, 32'hDEADBEEF);
    while (!bus.req_ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.rsp_valid) saw_rsp = 1'b1;
      if (bus.req_ready) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    check({name, " clear cycles"}, cnt, 32'd16);
    check({name, " no rsp during clear"}, {31'd0, saw_rsp}, 32'd0);
    check({name, " busy after clear"}, {31'd0, bus.init_busy}, 32'd0);
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    exp_t        q[$];
    exp_t        e;
    logic        we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_size = 2'd0; bus.req_unsigned = 1'b0; bus.req_wdata = 32'd0;

    tbl[0]  = mkv(1'b0, 32'h3C, 2'd2, 1'b0, 32'h0, 32'h00000000, 1'b0);
    tbl[1]  = mkv(1'b1, 32'h08, 2'd2, 1'b0, 32'h11223344, 32'h0, 1'b0);
    tbl[2]  = mkv(1'b1, 32'h09, 2'd0, 1'b0, 32'h000000F0, 32'h0, 1'b0);
    tbl[3]  = mkv(1'b1, 32'h0A, 2'd1, 1'b0, 32'h1234BEEF, 32'h0, 1'b0);
    tbl[4]  = mkv(1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 32'hBEEFF044, 1'b0);
    tbl[5]  = mkv(1'b0, 32'h09, 2'd0, 1'b0, 32'h0, 32'hFFFFFFF0, 1'b0);
    tbl[6]  = mkv(1'b0, 32'h0A, 2'd1, 1'b1, 32'h0, 32'h0000BEEF, 1'b0);
    tbl[7]  = mkv(1'b0, 32'h09, 2'd0, 1'b1, 32'h0, 32'h000000F0, 1'b0);
    tbl[8]  = mkv(1'b0, 32'h0A, 2'd1, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
    tbl[9]  = mkv(1'b0, 32'h0B, 2'd0, 1'b0, 32'h0, 32'hFFFFFFBE, 1'b0);
    tbl[10] = mkv(1'b0, 32'h08, 2'd0, 1'b0, 32'h0, 32'h00000044, 1'b0);
    tbl[11] = mkv(1'b1, 32'h04, 2'd2, 1'b0, 32'h55667788, 32'h0, 1'b0);
    tbl[12] = mkv(1'b1, 32'h05, 2'd1, 1'b0, 32'h0000AAAA, 32'h0, 1'b1);
    tbl[13] = mkv(1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 32'h55667788, 1'b0);
    tbl[14] = mkv(1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[15] = mkv(1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[16] = mkv(1'b0, 32'h00, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[17] = mkv(1'b1, 32'h0C, 2'd3, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1);
    tbl[18] = mkv(1'b1, 32'h0F, 2'd0, 1'b0, 32'h123456AB, 32'h0, 1'b0);
    tbl[19] = mkv(1'b0, 32'h0C, 2'd2, 1'b0, 32'h0, 32'hAB000000, 1'b0);
    tbl[20] = mkv(1'b0, 32'h06, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
    tbl[21] = mkv(1'b0, 32'h06, 2'd1, 1'b1, 32'h0, 32'h00005566, 1'b0);
    tbl[22] = mkv(1'b1, 32'h3E, 2'd2, 1'b0, 32'h77777777, 32'h0, 1'b1);

    // Reset state.
    #1;
    check("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset rsp_err", {31'd0, bus.rsp_err}, 32'd0);
    check("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("reset init_busy", {31'd0, bus.init_busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("first", 1'b0);

    // Directed vectors.
    for (int i = 0; i < 23; i++) begin
      single($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].uns,
             tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
    end
    @(negedge clk);
    check("idle rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("idle rsp_rdata", bus.rsp_rdata, 32'd0);

    // Back-to-back store then load of the same word.
    model_access(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEBABE, e.rd, e.err);
    drive(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEBABE);
    @(negedge clk);
    check("b2b store valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b store rdata", bus.rsp_rdata, 32'd0);
    drive(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b load valid", {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b load rdata", bus.rsp_rdata, 32'hCAFEBABE);
    @(negedge clk);

    // Random streaming at one request per cycle.
    for (int k = 0; k <= 64; k++) begin
      if (k > 0) begin
        e = q.pop_front();
        check($sformatf("stream%0d valid", k - 1), {31'd0, bus.rsp_valid}, 32'd1);
        check($sformatf("stream%0d rdata", k - 1), bus.rsp_rdata, e.rd);
        check($sformatf("stream%0d err", k - 1), {31'd0, bus.rsp_err}, {31'd0, e.err});
      end
      if (k < 64) begin
        we    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 2));
        uns   = 1'($urandom_range(0, 1));
        addr  = 32'($urandom_range(0, MemBytes - 1)) & ~((32'd1 << size) - 32'd1);
        wdata = $urandom;
        model_access(we, addr, size, uns, wdata, e.rd, e.err);
        q.push_back(e);
        drive(we, addr, size, uns, wdata);
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("stream tail idle", {31'd0, bus.rsp_valid}, 32'd0);

    // Reset with a response pending, then reset again mid-clear.
    drive(1'b0, 32'h08, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("pending rsp visible", {31'd0, bus.rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("pending rsp dropped", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst rdata zero", bus.rsp_rdata, 32'd0);
    check("rst ready low", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("mid-clear busy", {31'd0, bus.init_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-clear rst busy", {31'd0, bus.init_busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("restart", 1'b1);
    single("post-clear word8", 1'b0, 32'h08, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    single("post-clear word4", 1'b0, 32'h04, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised byte-addressable data memory with an integrated load/store unit for the unpipelined RV32 core. It accepts one load or store per cycle over a valid/ready request port and returns a registered response one cycle later. It handles byte, halfword and word accesses with byte-lane write enables and sign/zero extension. It flags misaligned, out-of-range and illegal-size accesses, and optionally zero-clears the whole array after reset with a clear FSM.

## Interface
Parameters:
- DEPTH_LOG2, 10: log2 of the number of 32-bit words. Array size is 2^DEPTH_LOG2 words (4 KiB by default).
- CLEAR_ON_RESET, 1: 1 = zero every word after reset before accepting requests; 0 = contents undefined and ready immediately.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: reset, asynchronous assert, active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: unit can accept a request this cycle.
- req_we, in, 1: 1 = store, 0 = load.
- req_addr, in, 32: byte address.
- req_size, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned, in, 1: loads only. 1 = zero-extend, 0 = sign-extend.
- req_wdata, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid, out, 1: one-cycle pulse, response for the request accepted on the previous edge.
- rsp_rdata, out, 32: load result, extended to 32 bits; 0 for stores and errors.
- rsp_err, out, 1: access error, qualified by rsp_valid.
- init_busy, out, 1: clear FSM is active.

## Operation
- **Accept condition.** A request is accepted on a rising edge where req_valid && req_ready.
- **Word index and byte offset.**
  - Word index = req_addr[DEPTH_LOG2+1:2].
  - Byte offset = req_addr[1:0].
- **Error conditions.** Each of the following sets rsp_err:
  - Out-of-range: req_addr[31:DEPTH_LOG2+2] != 0.
  - Misaligned: half with offset[0] = 1, or word with offset != 00.
  - Illegal size: req_size = 11.
- **Error response.** An erroring request writes nothing. It returns rsp_rdata = 0 and rsp_err = 1.
- **Store.** Byte lanes are written according to size and offset:
  - Byte: lane = offset, data = wdata[7:0] replicated into the lane.
  - Half: lanes {offset+1, offset}, data = wdata[15:0].
  - Word: all four lanes.
  - Unwritten lanes keep their value.
  - The response has rsp_rdata = 0 and rsp_err = 0.
- **Load.** The word is read synchronously. Size, offset and unsigned are registered alongside it. The selected byte or half is shifted down to bit 0, then sign- or zero-extended. Word loads return the word unchanged.
- **Clear FSM.** States are CLEAR and RUN.
  - After reset, the FSM enters CLEAR if CLEAR_ON_RESET = 1, otherwise RUN.
  - In CLEAR, it writes 0 to word clr_cnt each cycle, with clr_cnt counting from 0 up to 2^DEPTH_LOG2 - 1.
  - After the last word it moves to RUN.
  - init_busy = (state == CLEAR). req_ready = (state == RUN).
- **No backpressure on the response.** There is no response-side ready. The consumer must accept every rsp_valid pulse.

## Timing
- **Reset values.** On rst_n = 0, outputs take these values immediately:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 0 if CLEAR_ON_RESET, else 1.
  - init_busy = CLEAR_ON_RESET.
  - clr_cnt = 0.
  - Array contents are not touched by the reset itself.
- **Reset mid-operation.** A pending response is dropped, with no rsp_valid. Reset during CLEAR restarts the clear from word 0.
- **Latency and throughput.** Latency is exactly 1 cycle: a request accepted at edge N has its response valid from edge N to edge N+1. Throughput is 1 request per cycle when req_ready = 1.
- **Back-to-back ordering.** Requests to the same word complete in order. A store accepted at edge N followed by a load accepted at edge N+1 returns the stored data, since the write completes at edge N.
- **Clear duration.** With CLEAR_ON_RESET = 1, req_ready rises 2^DEPTH_LOG2 cycles after rst_n deasserts, on the edge after the final clear write. Requests presented earlier are not accepted.
- **Idle outputs.** rsp_rdata and rsp_err are held at 0 when rsp_valid = 0.

## Test plan
- **Reset clear:** reset with DEPTH_LOG2 = 4 and CLEAR_ON_RESET = 1.
  - Expect req_ready low for exactly 16 cycles after rst_n rises.
  - Then load word from 0x3C → rsp_rdata = 0x00000000.
- **Byte/half store and sign extension:**
  - Store word 0x11223344 at 0x8, then byte 0xF0 at 0x9, then half 0xBEEF at 0xA.
  - Load word 0x8 → 0xBEEFF044.
  - Load byte signed 0x9 → 0xFFFFFFF0.
  - Load half unsigned 0xA → 0x0000BEEF.
- **Errors:**
  - Half store at 0x5 → rsp_err = 1; memory unchanged (load word 0x4 is unchanged).
  - Word load at 0x1000 with DEPTH_LOG2 = 10 → rsp_err = 1, rdata 0.
  - req_size = 11 → rsp_err = 1.
- **Back-to-back:**
  - Store 0xCAFEBABE at 0x20, then load 0x20 in the next cycle.
  - Expect two consecutive rsp_valid pulses; the second returns 0xCAFEBABE.
- **Reset mid-clear:**
  - Assert rst_n = 0 when clr_cnt = 7, then release.
  - Expect the full 2^DEPTH_LOG2-cycle clear again, with rsp_valid = 0 throughout.
- **Streaming:** 64 random aligned loads and stores at 1 per cycle against a reference model; every response matches with 1-cycle latency.
